// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared policy encodings, defaults and LFSR helper for cache_repl_engine
package cache_pkg;

  localparam int POL_RANDOM = 0;
  localparam int POL_PLRU   = 1;
  localparam int POL_LRU    = 2;

  localparam int DEF_WAYS   = 4;
  localparam int DEF_SETS   = 64;
  localparam int DEF_POLICY = POL_RANDOM;
  localparam int DEF_CNT_W  = 32;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/plru_tree.sv
// rtl/plru_tree.sv - tree pseudo-LRU victim walk and touch update for one set
module plru_tree
  import cache_pkg::*;
#(
  parameter int WAYS = DEF_WAYS,
  localparam int LVLS = $clog2(WAYS)
) (
  input  logic [WAYS-2:0] tree_i,
  input  logic [LVLS-1:0] touch_way,
  output logic [LVLS-1:0] victim_way,
  output logic [WAYS-2:0] tree_o
);

  localparam int NW = (WAYS > 2) ? $clog2(WAYS - 1) : 1;

  // Heap-ordered nodes: children of node n live at 2n+1 (lower) and 2n+2 (upper)
  always_comb begin : p_victim
    logic [NW-1:0] node;
    node       = '0;
    victim_way = '0;
    for (int l = 0; l < LVLS; l++) begin
      victim_way = (victim_way << 1) | LVLS'(tree_i[node]);
      node       = (node << 1) + NW'(1) + NW'(tree_i[node]);
    end
  end

  always_comb begin : p_touch
    logic [NW-1:0] node;
    logic          b;
    node   = '0;
    tree_o = tree_i;
    for (int l = 0; l < LVLS; l++) begin
      b            = touch_way[LVLS-1-l];
      tree_o[node] = ~b;
      node         = (node << 1) + NW'(1) + NW'(b);
    end
  end

endmodule

// File: rtl/cache_repl_engine.sv
// rtl/cache_repl_engine.sv - per-set victim selection (RANDOM/PLRU/LRU) with hit/miss statistics
module cache_repl_engine
  import cache_pkg::*;
#(
  parameter int WAYS   = DEF_WAYS,
  parameter int SETS   = DEF_SETS,
  parameter int POLICY = DEF_POLICY,
  parameter int CNT_W  = DEF_CNT_W,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             access_valid,
  input  logic [SET_W-1:0] access_set,
  input  logic             access_hit,
  input  logic [WAY_W-1:0] access_way,
  input  logic [WAYS-1:0]  valid_mask,
  input  logic             clear_stats,
  output logic             victim_valid,
  output logic [WAY_W-1:0] victim_way,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int EFF_POLICY = (POLICY == POL_PLRU || POLICY == POL_LRU) ? POLICY : POL_RANDOM;

  logic             any_inv;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] pol_victim;
  logic [WAY_W-1:0] sel_victim;
  logic [WAY_W-1:0] touch_way;

  logic             victim_valid_q, victim_valid_d;
  logic [WAY_W-1:0] victim_way_q, victim_way_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;

  // Descending scan so the lowest-index invalid way is the last one written
  always_comb begin
    any_inv = 1'b0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_mask[i]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(i);
      end
    end
  end

  assign sel_victim = any_inv ? inv_way : pol_victim;
  assign touch_way  = access_hit ? access_way : sel_victim;

  generate
    if (EFF_POLICY == POL_LRU) begin : g_lru
      logic [WAY_W-1:0] age_q [SETS][WAYS];
      logic [WAY_W-1:0] age_d [WAYS];
      logic [WAY_W-1:0] lru_way;

      always_comb begin
        lru_way = '0;
        for (int w = 0; w < WAYS; w++) begin
          if (age_q[access_set][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
        end
      end

      always_comb begin : p_age_next
        logic [WAY_W-1:0] old_age;
        old_age = age_q[access_set][touch_way];
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == touch_way)              age_d[w] = '0;
          else if (age_q[access_set][w] < old_age) age_d[w] = age_q[access_set][w] + WAY_W'(1);
          else                                     age_d[w] = age_q[access_set][w];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
              age_q[s][w] <= WAY_W'(WAYS - 1 - w);
        end else if (access_valid) begin
          for (int w = 0; w < WAYS; w++) age_q[access_set][w] <= age_d[w];
        end
      end

      assign pol_victim = lru_way;
    end else if (EFF_POLICY == POL_PLRU) begin : g_plru
      logic [WAYS-2:0] tree_q [SETS];
      logic [WAYS-2:0] tree_d;

      plru_tree #(.WAYS(WAYS)) u_plru_tree (
        .tree_i     (tree_q[access_set]),
        .touch_way  (touch_way),
        .victim_way (pol_victim),
        .tree_o     (tree_d)
      );

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
        end else if (access_valid) begin
          tree_q[access_set] <= tree_d;
        end
      end
    end else begin : g_random
      logic [15:0] lfsr_q, lfsr_d;
      logic        unused_rand;

      assign lfsr_d      = lfsr_next(lfsr_q);
      assign pol_victim  = lfsr_q[WAY_W-1:0];
      assign unused_rand = ^{touch_way, access_set};

      always_ff @(posedge clk) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
      end
    end
  endgenerate

  // Clear takes priority over an increment landing in the same cycle
  always_comb begin
    victim_valid_d = access_valid & ~access_hit;
    victim_way_d   = victim_valid_d ? sel_victim : victim_way_q;
    hit_count_d    = hit_count_q;
    miss_count_d   = miss_count_q;
    if (clear_stats) begin
      hit_count_d  = '0;
      miss_count_d = '0;
    end else if (access_valid) begin
      if (access_hit && !(&hit_count_q))    hit_count_d  = hit_count_q + CNT_W'(1);
      if (!access_hit && !(&miss_count_q))  miss_count_d = miss_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      hit_count_q    <= '0;
      miss_count_q   <= '0;
    end else begin
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
      hit_count_q    <= hit_count_d;
      miss_count_q   <= miss_count_d;
    end
  end

  assign victim_valid = victim_valid_q;
  assign victim_way   = victim_way_q;
  assign hit_count    = hit_count_q;
  assign miss_count   = miss_count_q;

endmodule

// File: tb/tb_cache_repl_engine.sv
// tb/tb_cache_repl_engine.sv - randomized bench for cache_repl_engine against a recency-list/tree reference
module tb_cache_repl_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0;
  logic [5:0] a_set = '0;
  logic       a_hit = 1'b0;
  logic [1:0] a_way = '0;
  logic [3:0] mask = 4'hF;
  logic       clr = 1'b0;

  always #5 clk = ~clk;

  logic        vv_r, vv_p, vv_l, vv_3;
  logic [1:0]  w_r, w_p, w_l, w_3;
  logic [31:0] h_r, m_r, h_p, m_p, h_3, m_3;
  logic [3:0]  h_l, m_l;

  cache_repl_engine #(.WAYS(4), .SETS(64), .POLICY(0), .CNT_W(32)) u_rnd (
    .clk(clk), .rst_n(rst_n), .access_valid(a_valid), .access_set(a_set), .access_hit(a_hit),
    .access_way(a_way), .valid_mask(mask), .clear_stats(clr), .victim_valid(vv_r),
    .victim_way(w_r), .hit_count(h_r), .miss_count(m_r));

  cache_repl_engine #(.WAYS(4), .SETS(8), .POLICY(1), .CNT_W(32)) u_plru (
    .clk(clk), .rst_n(rst_n), .access_valid(a_valid), .access_set(a_set[2:0]), .access_hit(a_hit),
    .access_way(a_way), .valid_mask(mask), .clear_stats(clr), .victim_valid(vv_p),
    .victim_way(w_p), .hit_count(h_p), .miss_count(m_p));

  cache_repl_engine #(.WAYS(4), .SETS(8), .POLICY(2), .CNT_W(4)) u_lru (
    .clk(clk), .rst_n(rst_n), .access_valid(a_valid), .access_set(a_set[2:0]), .access_hit(a_hit),
    .access_way(a_way), .valid_mask(mask), .clear_stats(clr), .victim_valid(vv_l),
    .victim_way(w_l), .hit_count(h_l), .miss_count(m_l));

  cache_repl_engine #(.WAYS(4), .SETS(8), .POLICY(3), .CNT_W(32)) u_p3 (
    .clk(clk), .rst_n(rst_n), .access_valid(a_valid), .access_set(a_set[2:0]), .access_hit(a_hit),
    .access_way(a_way), .valid_mask(mask), .clear_stats(clr), .victim_valid(vv_3),
    .victim_way(w_3), .hit_count(h_3), .miss_count(m_3));

  // Instance order everywhere: 0 random, 1 plru, 2 lru (4-bit counters), 3 out-of-range policy
  logic        got_vv   [4];
  logic [1:0]  got_way  [4];
  logic [31:0] got_hit  [4];
  logic [31:0] got_miss [4];
  assign got_vv[0] = vv_r;  assign got_way[0] = w_r;  assign got_hit[0] = h_r;          assign got_miss[0] = m_r;
  assign got_vv[1] = vv_p;  assign got_way[1] = w_p;  assign got_hit[1] = h_p;          assign got_miss[1] = m_p;
  assign got_vv[2] = vv_l;  assign got_way[2] = w_l;  assign got_hit[2] = {28'd0, h_l}; assign got_miss[2] = {28'd0, m_l};
  assign got_vv[3] = vv_3;  assign got_way[3] = w_3;  assign got_hit[3] = h_3;          assign got_miss[3] = m_3;

  int          ord    [8][4];
  bit          plru_b [8][3];
  logic [15:0] lfsr_m;
  logic        exp_vv   [4];
  logic [1:0]  exp_way  [4];
  logic [31:0] exp_hit  [4];
  logic [31:0] exp_miss [4];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;

  function automatic logic [31:0] cmax(int k);
    return (k == 2) ? 32'd15 : 32'hFFFF_FFFF;
  endfunction

  function automatic int plru_pick(int s);
    int lo = 0, hi = 4, n = 0, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (!plru_b[s][n]) begin hi = mid; n = 2 * n + 1; end
      else               begin lo = mid; n = 2 * n + 2; end
    end
    return lo;
  endfunction

  task automatic plru_touch(int s, int t);
    int lo = 0, hi = 4, n = 0, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (t < mid) begin plru_b[s][n] = 1'b1; hi = mid; n = 2 * n + 1; end
      else         begin plru_b[s][n] = 1'b0; lo = mid; n = 2 * n + 2; end
    end
  endtask

  // ord[s][0] is most recently used, ord[s][3] is the replacement candidate
  task automatic lru_touch(int s, int t);
    int p = 0;
    for (int i = 0; i < 4; i++) if (ord[s][i] == t) p = i;
    for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
    ord[s][0] = t;
  endtask

  task automatic drive(bit r, bit v, int s, bit h, int w, logic [3:0] m, bit c);
    rst_n = r; a_valid = v; a_set = 6'(s); a_hit = h; a_way = 2'(w); mask = m; clr = c;
  endtask

  task automatic step();
    int s, inv, v, t;
    s = int'(a_set[2:0]);
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        ord[i] = '{3, 2, 1, 0};
        plru_b[i] = '{0, 0, 0};
      end
      lfsr_m = 16'hACE1;
      for (int k = 0; k < 4; k++) begin
        exp_vv[k] = 0; exp_way[k] = 0; exp_hit[k] = 0; exp_miss[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) exp_vv[k] = 0;
      if (a_valid) begin
        inv = -1;
        for (int i = 3; i >= 0; i--) if (!mask[i]) inv = i;
        for (int k = 0; k < 4; k++) begin
          if (inv >= 0)    v = inv;
          else if (k == 1) v = plru_pick(s);
          else if (k == 2) v = ord[s][3];
          else             v = int'(lfsr_m[1:0]);
          t = a_hit ? int'(a_way) : v;
          if (k == 1) plru_touch(s, t);
          if (k == 2) lru_touch(s, t);
          if (!a_hit) begin
            exp_vv[k] = 1; exp_way[k] = 2'(v);
            if (exp_miss[k] != cmax(k)) exp_miss[k] = exp_miss[k] + 1;
          end else if (exp_hit[k] != cmax(k)) begin
            exp_hit[k] = exp_hit[k] + 1;
          end
        end
      end
      if (clr) for (int k = 0; k < 4; k++) begin exp_hit[k] = 0; exp_miss[k] = 0; end
      lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    drive(0, 1, 2, 0, 0, 4'hF, 0);
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (got_vv[k] !== 1'b0 || got_way[k] !== 2'd0) begin
        n_err++; $display("FAIL reset_victim inst=%0d got vv=%b way=%0d want vv=0 way=0", k, got_vv[k], got_way[k]);
      end
      n_vec++;
      if (got_hit[k] !== 32'd0 || got_miss[k] !== 32'd0) begin
        n_err++; $display("FAIL reset_counts inst=%0d got hit=%0d miss=%0d want 0 0", k, got_hit[k], got_miss[k]);
      end
    end
  endtask

  task automatic test_random_first();
    drive(1, 1, 0, 0, 0, 4'hF, 0);
    step();
    n_vec++;
    if (got_vv[0] !== 1'b1 || got_way[0] !== 2'd1) begin
      n_err++; $display("FAIL rnd_first got vv=%b way=%0d want vv=1 way=1", got_vv[0], got_way[0]);
    end
    n_vec++;
    if (got_way[3] !== 2'd1) begin
      n_err++; $display("FAIL policy3_first got way=%0d want 1", got_way[3]);
    end
    n_vec++;
    if (got_way[1] !== 2'd0 || got_way[2] !== 2'd0) begin
      n_err++; $display("FAIL first_miss got plru=%0d lru=%0d want 0 0", got_way[1], got_way[2]);
    end
    drive(1, 0, 0, 0, 0, 4'hF, 0);
    step();
    n_vec++;
    if (got_vv[0] !== 1'b0 || got_way[0] !== 2'd1) begin
      n_err++; $display("FAIL rnd_hold got vv=%b way=%0d want vv=0 way=1", got_vv[0], got_way[0]);
    end
  endtask

  task automatic test_lru_sequence();
    logic [1:0] want [5];
    want = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    drive(0, 0, 0, 0, 0, 4'hF, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0, 0, 4'hF, 0);
      step();
      n_vec++;
      if (got_vv[2] !== 1'b1 || got_way[2] !== want[i]) begin
        n_err++; $display("FAIL lru_seq miss=%0d got vv=%b way=%0d want vv=1 way=%0d", i, got_vv[2], got_way[2], want[i]);
      end
    end
    n_vec++;
    if (got_miss[2] !== 32'd5) begin
      n_err++; $display("FAIL lru_miss_count got %0d want 5", got_miss[2]);
    end
  endtask

  task automatic test_plru();
    drive(0, 0, 0, 0, 0, 4'hF, 0);
    step();
    drive(1, 1, 3, 1, 0, 4'hF, 0); step();
    drive(1, 1, 3, 1, 2, 4'hF, 0); step();
    drive(1, 1, 3, 0, 0, 4'hF, 0); step();
    n_vec++;
    if (got_vv[1] !== 1'b1 || got_way[1] !== 2'd1) begin
      n_err++; $display("FAIL plru_walk got vv=%b way=%0d want vv=1 way=1", got_vv[1], got_way[1]);
    end
  endtask

  task automatic test_mask();
    drive(1, 1, 4, 0, 0, 4'b1011, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (got_vv[k] !== 1'b1 || got_way[k] !== 2'd2) begin
        n_err++; $display("FAIL mask_fill inst=%0d got vv=%b way=%0d want vv=1 way=2", k, got_vv[k], got_way[k]);
      end
    end
    drive(1, 0, 4, 0, 0, 4'hF, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (got_vv[k] !== 1'b0 || got_way[k] !== 2'd2) begin
        n_err++; $display("FAIL mask_pulse inst=%0d got vv=%b way=%0d want vv=0 way=2", k, got_vv[k], got_way[k]);
      end
    end
  endtask

  task automatic test_saturation();
    drive(0, 0, 0, 0, 0, 4'hF, 0);
    step();
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, int'($urandom_range(0, 7)), 1, int'($urandom_range(0, 3)), 4'hF, 0);
      step();
    end
    n_vec++;
    if (got_hit[2] !== 32'd15) begin
      n_err++; $display("FAIL hit_saturate got %0d want 15", got_hit[2]);
    end
    n_vec++;
    if (got_hit[0] !== 32'd20) begin
      n_err++; $display("FAIL hit_count32 got %0d want 20", got_hit[0]);
    end
    drive(1, 1, 1, 1, 1, 4'hF, 1);
    step();
    n_vec++;
    if (got_hit[2] !== 32'd0 || got_hit[0] !== 32'd0) begin
      n_err++; $display("FAIL clear_wins got lru=%0d rnd=%0d want 0 0", got_hit[2], got_hit[0]);
    end
  endtask

  task automatic test_reset_after_miss();
    drive(1, 1, 1, 0, 0, 4'hF, 0);
    step();
    drive(0, 1, 0, 0, 0, 4'hF, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (got_vv[k] !== 1'b0 || got_hit[k] !== 32'd0 || got_miss[k] !== 32'd0) begin
        n_err++; $display("FAIL reset_discard inst=%0d got vv=%b hit=%0d miss=%0d want 0 0 0", k, got_vv[k], got_hit[k], got_miss[k]);
      end
    end
    drive(1, 1, 0, 0, 0, 4'hF, 0);
    step();
    n_vec++;
    if (got_vv[2] !== 1'b1 || got_way[2] !== 2'd0) begin
      n_err++; $display("FAIL post_reset_lru got vv=%b way=%0d want vv=1 way=0", got_vv[2], got_way[2]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 5, 0, 0, 4'hF, 0);
      step();
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (got_vv[k] !== exp_vv[k] || got_way[k] !== exp_way[k]) begin
          n_err++; $display("FAIL b2b inst=%0d i=%0d got vv=%b way=%0d want vv=%b way=%0d", k, i, got_vv[k], got_way[k], exp_vv[k], exp_way[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] m;
    for (int i = 0; i < 400; i++) begin
      m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) != 0), int'($urandom_range(0, 7)),
            1'($urandom), int'($urandom_range(0, 3)), m, ($urandom_range(0, 29) == 0));
      step();
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (got_vv[k] !== exp_vv[k] || got_way[k] !== exp_way[k]) begin
          n_err++; $display("FAIL rand_victim inst=%0d cyc=%0d got vv=%b way=%0d want vv=%b way=%0d", k, cyc, got_vv[k], got_way[k], exp_vv[k], exp_way[k]);
        end
        n_vec++;
        if (got_hit[k] !== exp_hit[k] || got_miss[k] !== exp_miss[k]) begin
          n_err++; $display("FAIL rand_counts inst=%0d cyc=%0d got hit=%0d miss=%0d want hit=%0d miss=%0d", k, cyc, got_hit[k], got_miss[k], exp_hit[k], exp_miss[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_random_first();
    test_lru_sequence();
    test_plru();
    test_mask();
    test_saturation();
    test_reset_after_miss();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
